// File: rtl/s1s2_pack_pkg.sv
// Shared constants for the S1S2 reader/packer: FSM encodings and sizing helpers.
package s1s2_pack_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Counter width for v distinct values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int depth_p(input int nn, input int dd);
    return (2 * nn + dd - 1) / dd;
  endfunction

endpackage

// File: rtl/s1s2_pack_if.sv
// Handshake, S1S2 read port and packed-memory write port of the packer.
interface s1s2_pack_if #(
  parameter int M     = 79,
  parameter int WIDTH = 395,
  parameter int AW    = 7,
  parameter int PAW   = 5
);
  logic             start;
  logic             busy;
  logic             finish;
  logic [2*M-1:0]   S1S2_din;
  logic [AW-1:0]    S1S2_addr;
  logic             S1S2_rw;
  logic [WIDTH-1:0] P_dout;
  logic [PAW-1:0]   P_addr;
  logic             P_rw;

  // master is the packer itself; slave is the surrounding system
  modport master (
    input  start, S1S2_din,
    output busy, finish, S1S2_addr, S1S2_rw, P_dout, P_addr, P_rw
  );

  modport slave (
    output start, S1S2_din,
    input  busy, finish, S1S2_addr, S1S2_rw, P_dout, P_addr, P_rw
  );
endinterface

// File: rtl/s1s2_pack_shift.sv
// Pack shift register and slot counter; new elements enter at the LSB end so
// the oldest element of a full word sits in the MSBs.
module s1s2_pack_shift #(
  parameter int M   = 79,
  parameter int D   = 5,
  parameter int REM = 4,
  parameter int SW  = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           cap,
  input  logic [M-1:0]   din_hi,
  output logic [M*D-1:0] pack_next,
  output logic           slot_full,
  output logic [M*D-1:0] pad_word
);
  localparam int WIDTH = M * D;

  logic [WIDTH-1:0] pack_q, pack_d;
  logic [SW-1:0]    slot_q, slot_d;

  generate
    if (D > 1) begin : g_shift
      assign pack_next = {pack_q[WIDTH-M-1:0], din_hi};
    end else begin : g_single
      assign pack_next = din_hi;
    end
  endgenerate

  // Tail word: push stale older elements out the top, zero-fill the empty slots.
  generate
    if (REM == 0) begin : g_no_pad
      assign pad_word = '0;
    end else begin : g_pad
      assign pad_word = pack_next << ((D - REM) * M);
    end
  endgenerate

  assign slot_full = cap && (slot_q == SW'(D - 1));

  always_comb begin
    pack_d = pack_q;
    slot_d = slot_q;
    if (clr) begin
      pack_d = '0;
      slot_d = '0;
    end else if (cap) begin
      pack_d = pack_next;
      slot_d = slot_full ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q <= '0;
      slot_q <= '0;
    end else begin
      pack_q <= pack_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/s1s2_pack.sv
// Walks all 2n S1S2 entries, packs the product fields d per word and writes
// them to packed memory P, finishing with a zero-padded tail word if needed.
module s1s2_pack
  import s1s2_pack_pkg::*;
#(
  parameter int n        = 47,
  parameter int m        = 79,
  parameter int d        = 5,
  parameter int DELAY_rd = 1
) (
  input  logic       clk,
  input  logic       rst,
  s1s2_pack_if.master bus
);
  localparam int WIDTH   = m * d;
  localparam int DEPTH_P = depth_p(n, d);
  localparam int AW      = clog2_min1(2 * n);
  localparam int PAW     = clog2_min1(DEPTH_P);
  localparam int SW      = clog2_min1(d);
  localparam int REM     = (2 * n) % d;
  localparam int LAST    = 2 * n - 1;

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      cap_cnt_q, cap_cnt_d;
  logic [DELAY_rd-1:0] vld_q, vld_d;
  logic [PAW-1:0]     wcnt_q, wcnt_d;
  logic [PAW-1:0]     p_addr_q, p_addr_d;
  logic [WIDTH-1:0]   p_dout_q, p_dout_d;
  logic               p_rw_q, p_rw_d;

  logic               accept, issue, cap_valid, last_cap, pad_fire;
  logic               slot_full;
  logic [WIDTH-1:0]   pack_next, pad_word;
  logic               unused_lo;

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign issue     = (state_q == ST_READ);
  assign cap_valid = vld_q[DELAY_rd-1];
  assign last_cap  = cap_valid && (cap_cnt_q == AW'(LAST));
  assign pad_fire  = last_cap && (REM != 0);
  assign unused_lo = ^bus.S1S2_din[m-1:0];

  // Valid tag travels alongside each outstanding read for the memory latency.
  genvar gi;
  generate
    for (gi = 0; gi < DELAY_rd; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_d[gi] = issue;
      end else begin : g_tail
        assign vld_d[gi] = vld_q[gi-1];
      end
    end
  endgenerate

  s1s2_pack_shift #(
    .M   (m),
    .D   (d),
    .REM (REM),
    .SW  (SW)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .cap       (cap_valid),
    .din_hi    (bus.S1S2_din[2*m-1:m]),
    .pack_next (pack_next),
    .slot_full (slot_full),
    .pad_word  (pad_word)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cap_cnt_d = cap_cnt_q;
    wcnt_d    = wcnt_q;
    p_addr_d  = p_addr_q;
    p_dout_d  = p_dout_q;
    p_rw_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_READ;
          addr_d    = '0;
          cap_cnt_d = '0;
          wcnt_d    = '0;
        end
      end
      ST_READ: begin
        if (addr_q == AW'(LAST)) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + AW'(1);
      end
      ST_DRAIN: if (last_cap) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (cap_valid) cap_cnt_d = cap_cnt_q + AW'(1);

    // The tail word is launched on the final capture, so it is on the port
    // during FLUSH and finish follows one cycle after the last write.
    if (slot_full) begin
      p_dout_d = pack_next;
      p_rw_d   = 1'b1;
      p_addr_d = wcnt_q;
      wcnt_d   = wcnt_q + PAW'(1);
    end else if (pad_fire) begin
      p_dout_d = pad_word;
      p_rw_d   = 1'b1;
      p_addr_d = PAW'(DEPTH_P - 1);
      wcnt_d   = wcnt_q + PAW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cap_cnt_q <= '0;
      vld_q     <= '0;
      wcnt_q    <= '0;
      p_addr_q  <= '0;
      p_dout_q  <= '0;
      p_rw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cap_cnt_q <= cap_cnt_d;
      vld_q     <= vld_d;
      wcnt_q    <= wcnt_d;
      p_addr_q  <= p_addr_d;
      p_dout_q  <= p_dout_d;
      p_rw_q    <= p_rw_d;
    end
  end

  assign bus.busy      = (state_q == ST_READ) || (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  assign bus.finish    = (state_q == ST_DONE);
  assign bus.S1S2_addr = addr_q;
  assign bus.S1S2_rw   = 1'b0;
  assign bus.P_dout    = p_dout_q;
  assign bus.P_addr    = p_addr_q;
  // A write still in the output register is suppressed while reset is high.
  assign bus.P_rw      = p_rw_q & ~rst;

endmodule

// File: tb/tb_s1s2_pack.sv
// Directed bench for s1s2_pack: three configurations (defaults, n=10, DELAY_rd=3).
module tb_s1s2_pack;
  localparam int W = 395;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  s1s2_pack_if #(.M(79), .WIDTH(395), .AW(7), .PAW(5)) if0 ();
  s1s2_pack_if #(.M(79), .WIDTH(395), .AW(5), .PAW(2)) if1 ();
  s1s2_pack_if #(.M(79), .WIDTH(395), .AW(7), .PAW(5)) if2 ();

  s1s2_pack #(.n(47), .m(79), .d(5), .DELAY_rd(1)) u0 (.clk(clk), .rst(rst), .bus(if0.master));
  s1s2_pack #(.n(10), .m(79), .d(5), .DELAY_rd(1)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
  s1s2_pack #(.n(47), .m(79), .d(5), .DELAY_rd(3)) u2 (.clk(clk), .rst(rst), .bus(if2.master));

  // memory models: entry i = {off+i+1, lo}
  logic [78:0]  off0 = 79'd0;
  logic [78:0]  lo0  = 79'h7FFF;
  logic [157:0] p2a, p2b;
  always @(posedge clk) begin
    if0.S1S2_din <= {off0 + 79'(if0.S1S2_addr) + 79'd1, lo0};
    if1.S1S2_din <= {79'(if1.S1S2_addr) + 79'd1, 79'h7FFF};
    p2a          <= {79'(if2.S1S2_addr) + 79'd1, 79'h7FFF};
    p2b          <= p2a;
    if2.S1S2_din <= p2b;
  end

  // write logs, sampled on the falling edge
  logic [W-1:0] ld0 [256];
  logic [W-1:0] ld1 [256];
  logic [W-1:0] ld2 [256];
  int la0 [256], la1 [256], la2 [256];
  int lc0 [256], lc1 [256], lc2 [256];
  int wt0 = 0, wt1 = 0, wt2 = 0;

  always @(negedge clk) begin
    if (if0.P_rw === 1'b1 && wt0 < 256) begin
      ld0[wt0] <= if0.P_dout; la0[wt0] <= int'(if0.P_addr); lc0[wt0] <= cyc_cnt; wt0 <= wt0 + 1;
    end
    if (if1.P_rw === 1'b1 && wt1 < 256) begin
      ld1[wt1] <= if1.P_dout; la1[wt1] <= int'(if1.P_addr); lc1[wt1] <= cyc_cnt; wt1 <= wt1 + 1;
    end
    if (if2.P_rw === 1'b1 && wt2 < 256) begin
      ld2[wt2] <= if2.P_dout; la2[wt2] <= int'(if2.P_addr); lc2[wt2] <= cyc_cnt; wt2 <= wt2 + 1;
    end
  end

  function automatic logic [W-1:0] exp_word(input int w, input int nn, input logic [78:0] off);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = w * 5 + k;
      if (idx < 2 * nn) r[W-1-k*79 -: 79] = off + 79'(idx) + 79'd1;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int u, input logic v);
    case (u)
      0: if0.start = v;
      1: if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  function automatic logic get_finish(input int u);
    case (u)
      0: return if0.finish;
      1: return if1.finish;
      default: return if2.finish;
    endcase
  endfunction

  // cyc = clock edges from the one that samples start to the first finish cycle
  task automatic run(input int u, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    set_start(u, 1'b1);
    tick;
    set_start(u, 1'b0);
    while (get_finish(u) !== 1'b1) begin
      tick;
      cyc++;
      if (cyc > 400) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({if0.busy, if0.finish, if0.P_rw, if0.S1S2_rw} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {if0.busy, if0.finish, if0.P_rw, if0.S1S2_rw});
    end
    checks++;
    if (if0.S1S2_addr !== 7'd0) begin errors++; $display("FAIL reset_s1s2_addr got %0d want 0", if0.S1S2_addr); end
    checks++;
    if (if0.P_addr !== 5'd0) begin errors++; $display("FAIL reset_p_addr got %0d want 0", if0.P_addr); end
    checks++;
    if (if0.P_dout !== '0) begin errors++; $display("FAIL reset_p_dout got %h want 0", if0.P_dout); end
    checks++;
    if ({if1.busy, if2.busy, if1.P_rw, if2.P_rw, if1.finish, if2.finish} !== 6'b0) begin
      errors++; $display("FAIL reset_other got %b want 000000", {if1.busy, if2.busy, if1.P_rw, if2.P_rw, if1.finish, if2.finish});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_default;
    int base, cyc, fin_cyc;
    bit to;
    base = wt0;
    run(0, cyc, to);
    fin_cyc = cyc_cnt;
    checks++;
    if (to) begin errors++; $display("FAIL t1_timeout got %0d cycles want finish", cyc); end
    checks++;
    if (cyc > 98) begin errors++; $display("FAIL t1_latency got %0d want <=98", cyc); end
    checks++;
    if (if0.busy !== 1'b0) begin errors++; $display("FAIL t1_busy_at_finish got %b want 0", if0.busy); end
    tick;
    checks++;
    if (if0.finish !== 1'b0) begin errors++; $display("FAIL t1_finish_width got %b want 0", if0.finish); end
    checks++;
    if (wt0 - base !== 19) begin errors++; $display("FAIL t1_count got %0d want 19", wt0 - base); end
    for (int w = 0; w < 19; w++) begin
      checks++;
      if (la0[base+w] !== w || ld0[base+w] !== exp_word(w, 47, 79'd0)) begin
        errors++;
        $display("FAIL t1_word%0d got addr %0d data %h want addr %0d data %h", w, la0[base+w], ld0[base+w], w, exp_word(w, 47, 79'd0));
      end
    end
    checks++;
    if (lc0[base+18] !== fin_cyc - 1) begin
      errors++; $display("FAIL t1_finish_after_last got write cycle %0d want %0d", lc0[base+18], fin_cyc - 1);
    end
  endtask

  task automatic test_even;
    int base, cyc, fin_cyc;
    bit to;
    base = wt1;
    run(1, cyc, to);
    fin_cyc = cyc_cnt;
    checks++;
    if (to) begin errors++; $display("FAIL t2_timeout got %0d cycles want finish", cyc); end
    tick;
    checks++;
    if (if1.finish !== 1'b0) begin errors++; $display("FAIL t2_finish_width got %b want 0", if1.finish); end
    repeat (3) tick;
    checks++;
    if (wt1 - base !== 4) begin errors++; $display("FAIL t2_count got %0d want 4", wt1 - base); end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (la1[base+w] !== w || ld1[base+w] !== exp_word(w, 10, 79'd0)) begin
        errors++;
        $display("FAIL t2_word%0d got addr %0d data %h want addr %0d data %h", w, la1[base+w], ld1[base+w], w, exp_word(w, 10, 79'd0));
      end
    end
    checks++;
    if (lc1[base+3] !== fin_cyc - 1) begin
      errors++; $display("FAIL t2_finish_after_last got write cycle %0d want %0d", lc1[base+3], fin_cyc - 1);
    end
  endtask

  task automatic test_delay3;
    int base, cyc;
    bit to;
    base = wt2;
    run(2, cyc, to);
    checks++;
    if (to || cyc > 101) begin errors++; $display("FAIL t3_latency got %0d want <=101", cyc); end
    tick;
    checks++;
    if (wt2 - base !== 19) begin errors++; $display("FAIL t3_count got %0d want 19", wt2 - base); end
    for (int w = 0; w < 19; w++) begin
      checks++;
      if (la2[base+w] !== w || ld2[base+w] !== exp_word(w, 47, 79'd0)) begin
        errors++;
        $display("FAIL t3_word%0d got addr %0d data %h want addr %0d data %h", w, la2[base+w], ld2[base+w], w, exp_word(w, 47, 79'd0));
      end
    end
  endtask

  task automatic test_start_ignored;
    int base, k, busy_low, idle_busy;
    base = wt0;
    busy_low = 0;
    idle_busy = 0;
    set_start(0, 1'b1);
    tick;
    set_start(0, 1'b0);
    k = 0;
    while (if0.finish !== 1'b1 && k <= 400) begin
      if (if0.busy !== 1'b1) busy_low++;
      set_start(0, (k == 5 || k == 20));
      tick;
      k++;
    end
    checks++;
    if (k > 98) begin errors++; $display("FAIL t4_latency got %0d want <=98", k); end
    set_start(0, 1'b1);
    tick;
    set_start(0, 1'b0);
    repeat (5) begin
      if (if0.busy !== 1'b0) idle_busy++;
      tick;
    end
    checks++;
    if (busy_low !== 0) begin errors++; $display("FAIL t4_busy_gap got %0d low cycles want 0", busy_low); end
    checks++;
    if (idle_busy !== 0) begin errors++; $display("FAIL t4_restart got %0d busy cycles want 0", idle_busy); end
    checks++;
    if (wt0 - base !== 19) begin errors++; $display("FAIL t4_count got %0d want 19", wt0 - base); end
    for (int w = 0; w < 19; w++) begin
      checks++;
      if (la0[base+w] !== w || ld0[base+w] !== exp_word(w, 47, 79'd0)) begin
        errors++;
        $display("FAIL t4_word%0d got addr %0d data %h want addr %0d data %h", w, la0[base+w], ld0[base+w], w, exp_word(w, 47, 79'd0));
      end
    end
  endtask

  task automatic test_reset_midrun;
    int base, wbefore, cyc;
    bit to;
    base = wt0;
    set_start(0, 1'b1);
    tick;
    set_start(0, 1'b0);
    repeat (30) tick;
    checks++;
    if (if0.busy !== 1'b1 || wt0 - base < 1) begin
      errors++; $display("FAIL t5_in_progress got busy %b writes %0d want busy 1 writes >=1", if0.busy, wt0 - base);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if0.P_rw !== 1'b0) begin errors++; $display("FAIL t5_prw_in_rst got %b want 0", if0.P_rw); end
    wbefore = wt0;
    tick;
    checks++;
    if ({if0.busy, if0.finish, if0.P_rw} !== 3'b000) begin
      errors++; $display("FAIL t5_reset_ctrl got %b want 000", {if0.busy, if0.finish, if0.P_rw});
    end
    checks++;
    if (if0.S1S2_addr !== 7'd0 || if0.P_addr !== 5'd0 || if0.P_dout !== '0) begin
      errors++; $display("FAIL t5_reset_data got s1s2 %0d paddr %0d pdout %h want 0 0 0", if0.S1S2_addr, if0.P_addr, if0.P_dout);
    end
    rst = 1'b0;
    repeat (5) tick;
    checks++;
    if (wt0 !== wbefore || if0.busy !== 1'b0) begin
      errors++; $display("FAIL t5_quiet got writes %0d busy %b want 0 0", wt0 - wbefore, if0.busy);
    end
    base = wt0;
    run(0, cyc, to);
    tick;
    checks++;
    if (to || wt0 - base !== 19) begin errors++; $display("FAIL t5_rerun_count got %0d want 19", wt0 - base); end
    for (int w = 0; w < 19; w++) begin
      checks++;
      if (la0[base+w] !== w || ld0[base+w] !== exp_word(w, 47, 79'd0)) begin
        errors++;
        $display("FAIL t5_word%0d got addr %0d data %h want addr %0d data %h", w, la0[base+w], ld0[base+w], w, exp_word(w, 47, 79'd0));
      end
    end
  endtask

  task automatic test_back_to_back;
    int base1, base2, cyc;
    bit to1, to2;
    base1 = wt0;
    run(0, cyc, to1);
    tick;
    off0 = 79'd1000;
    lo0  = 79'h1234;
    base2 = wt0;
    run(0, cyc, to2);
    tick;
    checks++;
    if (to1 || to2 || base2 - base1 !== 19) begin
      errors++; $display("FAIL t6_first_count got %0d want 19", base2 - base1);
    end
    checks++;
    if (wt0 - base2 !== 19) begin errors++; $display("FAIL t6_second_count got %0d want 19", wt0 - base2); end
    checks++;
    if (la0[base2] !== 0) begin errors++; $display("FAIL t6_addr_restart got %0d want 0", la0[base2]); end
    for (int w = 0; w < 19; w++) begin
      checks++;
      if (la0[base2+w] !== w || ld0[base2+w] !== exp_word(w, 47, 79'd1000)) begin
        errors++;
        $display("FAIL t6_word%0d got addr %0d data %h want addr %0d data %h", w, la0[base2+w], ld0[base2+w], w, exp_word(w, 47, 79'd1000));
      end
    end
  endtask

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
    test_reset;
    test_default;
    test_even;
    test_delay3;
    test_start_ignored;
    test_reset_midrun;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got time %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
